// File: rtl/router_pkt_rx_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : router_pkt_rx_if
// Brief    : Bundle of router-port, byte-sink and packet-status signals
//            shared by the packet receiver and its environment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface router_pkt_rx_if;
  // router port side
  logic        vld_out;
  logic [7:0]  data_out;
  logic        read_enb;
  // byte sink side
  logic        sink_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_sop;
  logic        byte_eop;
  // packet status
  logic        pkt_done;
  logic [5:0]  pkt_len;
  logic [1:0]  pkt_dest;
  logic        parity_err;
  logic        dest_err;
  logic        trunc_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  modport master (
    output vld_out, data_out, sink_ready,
    input  read_enb, byte_out, byte_valid, byte_sop, byte_eop,
    input  pkt_done, pkt_len, pkt_dest, parity_err, dest_err, trunc_err,
    input  pkt_count, err_count
  );

  modport slave (
    input  vld_out, data_out, sink_ready,
    output read_enb, byte_out, byte_valid, byte_sop, byte_eop,
    output pkt_done, pkt_len, pkt_dest, parity_err, dest_err, trunc_err,
    output pkt_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/router_pkt_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : router_pkt_rx
// Brief    : Drains one router output port, forwards packet bytes with zero
//            latency, checks parity/destination and aborts stalled packets.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module router_pkt_rx #(
  parameter logic [1:0]  PORT_ID = 2'd0,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic           clock,
  input  logic           resetn,
  router_pkt_rx_if.slave bus
);

  localparam int unsigned c_wdog_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_rd_q;
  logic [5:0]            r_len;
  logic [5:0]            r_remaining;
  logic [1:0]            r_dest;
  logic [7:0]            r_xor;
  logic [c_wdog_w-1:0]   r_wdog;

  logic                  r_pkt_done;
  logic [5:0]            r_pkt_len;
  logic [1:0]            r_pkt_dest;
  logic                  r_parity_err;
  logic                  r_dest_err;
  logic                  r_trunc_err;
  logic [15:0]           r_pkt_count;
  logic [15:0]           r_err_count;

  logic                  w_read;
  logic                  w_cap;
  logic [5:0]            w_hdr_len;
  logic                  w_in_pkt;
  logic                  w_abort;
  logic                  w_end_ok;
  logic                  w_finish;
  logic                  w_par_bad;
  logic                  w_dest_bad;
  logic                  w_any_err;

  // Popping needs only data available and room downstream; the byte shows up
  // one cycle later, which is the one byte the sink must absorb after a drop.
  assign w_read       = bus.vld_out & bus.sink_ready;
  assign bus.read_enb = w_read;

  assign w_cap      = r_rd_q;
  assign w_hdr_len  = bus.data_out[7:2];
  assign w_in_pkt   = (r_state != S_IDLE);
  assign w_abort    = w_in_pkt & ~w_cap & (r_wdog == c_wdog_last);
  assign w_end_ok   = w_cap & (r_state == S_PARITY);
  assign w_finish   = w_end_ok | w_abort;
  assign w_par_bad  = w_end_ok & (bus.data_out != r_xor);
  assign w_dest_bad = (r_dest != PORT_ID);
  assign w_any_err  = w_par_bad | w_dest_bad | w_abort;

  assign bus.byte_out   = bus.data_out;
  assign bus.byte_valid = w_cap;
  assign bus.byte_sop   = w_cap & (r_state == S_IDLE);
  assign bus.byte_eop   = w_cap & (r_state == S_PARITY);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rd_q <= 1'b0;
    end else begin
      r_rd_q <= w_read & bus.vld_out;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_remaining <= '0;
      r_dest      <= '0;
      r_xor       <= '0;
      r_wdog      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (w_cap) begin
            r_len       <= w_hdr_len;
            r_remaining <= w_hdr_len;
            r_dest      <= bus.data_out[1:0];
            r_xor       <= bus.data_out;
            r_state     <= (w_hdr_len == 6'd0) ? S_PARITY : S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (w_cap) begin
            r_xor       <= r_xor ^ bus.data_out;
            r_remaining <= r_remaining - 6'd1;
            r_wdog      <= '0;
            if (r_remaining == 6'd1) begin
              r_state <= S_PARITY;
            end
          end else if (w_abort) begin
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + c_wdog_w'(1);
          end
        end

        S_PARITY: begin
          // Returning to IDLE here lets a header land on the very next capture.
          if (w_cap) begin
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end else if (w_abort) begin
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + c_wdog_w'(1);
          end
        end

        default: begin
          r_wdog  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status registers only move on packet completion, so flags hold in between.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_done   <= 1'b0;
      r_pkt_len    <= '0;
      r_pkt_dest   <= '0;
      r_parity_err <= 1'b0;
      r_dest_err   <= 1'b0;
      r_trunc_err  <= 1'b0;
      r_pkt_count  <= '0;
      r_err_count  <= '0;
    end else begin
      r_pkt_done <= w_finish;
      if (w_finish) begin
        r_pkt_len    <= r_len;
        r_pkt_dest   <= r_dest;
        r_parity_err <= w_par_bad;
        r_dest_err   <= w_dest_bad;
        r_trunc_err  <= w_abort;
        if (w_any_err) begin
          if (r_err_count != c_cnt_max) begin
            r_err_count <= r_err_count + 16'd1;
          end
        end else begin
          if (r_pkt_count != c_cnt_max) begin
            r_pkt_count <= r_pkt_count + 16'd1;
          end
        end
      end
    end
  end

  assign bus.pkt_done   = r_pkt_done;
  assign bus.pkt_len    = r_pkt_len;
  assign bus.pkt_dest   = r_pkt_dest;
  assign bus.parity_err = r_parity_err;
  assign bus.dest_err   = r_dest_err;
  assign bus.trunc_err  = r_trunc_err;
  assign bus.pkt_count  = r_pkt_count;
  assign bus.err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/router_pkt_rx.md
ROUTER_PKT_RX -- requirements
Module: router_pkt_rx

Interface
REQ-001 Parameter PORT_ID, default 2'd0: router output port this block drains; expected header destination.
REQ-002 Parameter TIMEOUT, default 32: idle cycles tolerated mid-packet before abort.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 vld_out  input  1  router port FIFO non-empty.
REQ-006 data_out  input  8  router port read data; valid the cycle after read_enb is sampled high with vld_out high.
REQ-007 read_enb  output  1  pop request to router port.
REQ-008 sink_ready  input  1  downstream can accept a byte next cycle.
REQ-009 byte_out  output  8  forwarded packet byte.
REQ-010 byte_valid  output  1  byte_out valid this cycle.
REQ-011 byte_sop  output  1  with byte_valid: byte is a header.
REQ-012 byte_eop  output  1  with byte_valid: byte is a parity byte.
REQ-013 pkt_done  output  1  one-cycle pulse: packet ended (normal or aborted).
REQ-014 pkt_len  output  6  payload length of the last finished packet.
REQ-015 pkt_dest  output  2  header destination of the last finished packet.
REQ-016 parity_err  output  1  last packet's parity mismatch; valid with pkt_done, held until next pkt_done.
REQ-017 dest_err  output  1  last packet's header[1:0] != PORT_ID; same timing as parity_err.
REQ-018 trunc_err  output  1  last packet aborted by timeout; same timing as parity_err.
REQ-019 pkt_count  output  16  packets finished with no error.
REQ-020 err_count  output  16  packets finished with any error.

Function
REQ-021 Packet format: header {len[5:0], dest[1:0]}, then len payload bytes, then one parity byte equal to XOR of header and all payload bytes.
REQ-022 read_enb SHALL be combinational: vld_out & sink_ready; no other gating.
REQ-023 rd_q SHALL register (read_enb & vld_out); a byte is captured from data_out in every cycle where rd_q=1.
REQ-024 Captured bytes SHALL drive byte_out/byte_valid combinationally in the capture cycle (zero added latency); downstream SHALL accept one byte arriving after it drops sink_ready.
REQ-025 FSM states: IDLE, PAYLOAD, PARITY.
REQ-026 IDLE: captured byte is the header; latch len/dest, init XOR with it, assert byte_sop; go PAYLOAD if len>0, else PARITY.
REQ-027 PAYLOAD: each captured byte XORs into parity and decrements remaining count; when the last payload byte is captured, go PARITY.
REQ-028 PARITY: captured byte asserts byte_eop; compare with running XOR; next cycle pulse pkt_done, update pkt_len/pkt_dest/flags; go IDLE.
REQ-029 A header may be captured in the cycle immediately following a parity capture (back-to-back packets, no bubble).
REQ-030 Watchdog: in PAYLOAD or PARITY, count consecutive cycles with rd_q=0; reset the count on every capture; at TIMEOUT, pulse pkt_done with trunc_err=1, parity_err=0, go IDLE.
REQ-031 A packet with any of parity_err/dest_err/trunc_err SHALL increment err_count, else pkt_count; both counters saturate at 16'hFFFF.
REQ-032 dest_err packets SHALL still be parsed and forwarded in full.

Reset
REQ-033 On resetn low: FSM IDLE, watchdog/XOR/remaining cleared, rd_q=0; pkt_done, byte_valid, byte_sop, byte_eop, all error flags, pkt_len, pkt_dest, pkt_count, err_count = 0.
REQ-034 Reset mid-packet SHALL discard the partial packet without pkt_done; the first byte captured after release is treated as a header.

Verification
REQ-035 PORT_ID=2, len=14 dest=2 correct parity, sink_ready=1 -> 16 byte_valid cycles, sop on first, eop on last, pkt_done once, pkt_len=14, all errors 0, pkt_count=1.
REQ-036 len=8 dest=0 to PORT_ID=0, parity byte inverted -> parity_err=1, dest_err=0, err_count=1, pkt_count unchanged.
REQ-037 Three back-to-back len=2 dest=0 packets -> 12 bytes consecutive, three pkt_done pulses, pkt_count=3.
REQ-038 len=16, vld_out low after 5 captures for 32 cycles -> pkt_done with trunc_err=1 on watchdog expiry; next byte treated as header.
REQ-039 sink_ready dropped for 4 cycles mid-payload -> read_enb low same cycles, at most one byte delivered after drop, no byte lost or duplicated, parity_err=0.
REQ-040 resetn pulsed low after 3 payload bytes -> outputs at reset values, no pkt_done; following full packet decoded correctly.
